lfsr_seq_checker: RTL and testbench

LFSR_SEQ_CHECKER -- requirements
Module: lfsr_seq_checker

---
 rtl/lfsr_pkg.sv | 21 ++
 rtl/lfsr_seq_checker_if.sv | 27 ++
 rtl/lfsr_seq_checker.sv | 117 +++++++++++
 tb/tb_lfsr_seq_checker.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants, state encoding and next-state function for the team's 8-bit LFSR.
// The generator and the checker both import this package, so they cannot drift apart.
package lfsr_pkg;

    localparam int LFSR_W = 8;

    // Feedback taps on bits 7,5,4,3 (x^8+x^6+x^5+x^4+1)
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'h01;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } lfsr_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_seq_checker_if.sv
// Bundle of the checker's data input, counter clear, status outputs and debug state.
// valid/ready: there is no ready; a word is consumed on every rising edge where in_valid is high.
interface lfsr_seq_checker_if
    import lfsr_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic              in_valid;
    logic [LFSR_W-1:0] in_data;
    logic              clear_cnt;
    logic              locked;
    logic              err_pulse;
    logic [CNT_W-1:0]  err_count;
    logic [CNT_W-1:0]  word_count;
    lfsr_state_t       state;

    modport master (
        output in_valid, in_data, clear_cnt,
        input  locked, err_pulse, err_count, word_count, state
    );

    modport slave (
        input  in_valid, in_data, clear_cnt,
        output locked, err_pulse, err_count, word_count, state
    );

endinterface

// File: rtl/lfsr_seq_checker.sv
// Tracks a received LFSR word stream: hunts for a seed, confirms it, then flywheels
// the prediction while locked and counts mismatched and checked words.
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_MATCHES = 4,
    parameter int LOSS_ERRORS  = 3,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    lfsr_seq_checker_if.slave  bus
);

    localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
    localparam int MISS_W  = $clog2(LOSS_ERRORS + 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_MATCHES - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_ERRORS - 1);

    lfsr_state_t       r_state;
    logic [LFSR_W-1:0] r_pred;
    logic [MATCH_W-1:0] r_match_cnt;
    logic [MISS_W-1:0] r_miss_cnt;
    logic              r_locked;
    logic              r_err_pulse;
    logic [CNT_W-1:0]  r_err_count;
    logic [CNT_W-1:0]  r_word_count;

    logic w_hit;
    logic w_zero;
    logic w_err_sat;
    logic w_word_sat;

    assign w_hit      = (bus.in_data == r_pred);
    assign w_zero     = (bus.in_data == '0);
    assign w_err_sat  = &r_err_count;
    assign w_word_sat = &r_word_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_HUNT;
            r_pred       <= '0;
            r_match_cnt  <= '0;
            r_miss_cnt   <= '0;
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_count  <= '0;
            r_word_count <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            if (bus.clear_cnt) begin
                r_err_count  <= '0;
                r_word_count <= '0;
            end
            if (bus.in_valid) begin
                case (r_state)
                    ST_HUNT: begin
                        if (!w_zero) begin
                            r_pred      <= lfsr_next(bus.in_data);
                            r_match_cnt <= '0;
                            r_state     <= ST_SYNC;
                        end
                    end
                    ST_SYNC: begin
                        if (w_hit) begin
                            r_pred      <= lfsr_next(bus.in_data);
                            r_match_cnt <= r_match_cnt + 1'b1;
                            if (r_match_cnt == MATCH_LAST) begin
                                r_state    <= ST_LOCKED;
                                r_locked   <= 1'b1;
                                r_miss_cnt <= '0;
                            end
                        end else if (w_zero) begin
                            r_state <= ST_HUNT;
                        end else begin
                            r_pred      <= lfsr_next(bus.in_data);
                            r_match_cnt <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        // Flywheel: received data never reseeds once locked
                        r_pred <= lfsr_next(r_pred);
                        if (!bus.clear_cnt && !w_word_sat) begin
                            r_word_count <= r_word_count + 1'b1;
                        end
                        if (w_hit) begin
                            r_miss_cnt <= '0;
                        end else begin
                            r_err_pulse <= 1'b1;
                            if (!bus.clear_cnt && !w_err_sat) begin
                                r_err_count <= r_err_count + 1'b1;
                            end
                            if (r_miss_cnt == MISS_LAST) begin
                                r_state    <= ST_HUNT;
                                r_locked   <= 1'b0;
                                r_miss_cnt <= '0;
                            end else begin
                                r_miss_cnt <= r_miss_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state  <= ST_HUNT;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.locked     = r_locked;
    assign bus.err_pulse  = r_err_pulse;
    assign bus.err_count  = r_err_count;
    assign bus.word_count = r_word_count;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: vector table plus hand-written lock/reseed/saturation sequences.
module tb_lfsr_seq_checker;
    import lfsr_pkg::*;

    localparam int EXP_W = 36;
    localparam logic [1:0] H = 2'd0;
    localparam logic [1:0] S = 2'd1;
    localparam logic [1:0] L = 2'd2;

    logic clk;
    logic rst;
    logic rst_s;

    lfsr_seq_checker_if #(.CNT_W(16)) m_bus ();
    lfsr_seq_checker_if #(.CNT_W(16)) s_bus ();

    lfsr_seq_checker #(.LOCK_MATCHES(4), .LOSS_ERRORS(3), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m_bus)
    );

    lfsr_seq_checker #(.LOCK_MATCHES(4), .LOSS_ERRORS(70000), .CNT_W(16)) dut_sat (
        .clk (clk),
        .rst (rst_s),
        .bus (s_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        c;
        logic [1:0]  st;
        logic        lk;
        logic        ep;
        logic [15:0] ec;
        logic [15:0] wc;
    } vec_t;

    vec_t tbl[30];
    logic [EXP_W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic c,
                                input logic [1:0] st, input logic lk, input logic ep,
                                input logic [15:0] ec, input logic [15:0] wc);
        vec_t r;
        r.v = v; r.d = d; r.c = c; r.st = st; r.lk = lk; r.ep = ep; r.ec = ec; r.wc = wc;
        return r;
    endfunction

    function automatic logic [EXP_W-1:0] pk(input logic [1:0] st, input logic lk, input logic ep,
                                            input logic [15:0] ec, input logic [15:0] wc);
        return {st, lk, ep, ec, wc};
    endfunction

    task automatic check_pop(input logic [EXP_W-1:0] act, input string nm);
        logic [EXP_W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: no expected entry queued", nm);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                failures++;
                $display("FAIL %s: got st=%0d lk=%0b ep=%0b err=%h word=%h, expected st=%0d lk=%0b ep=%0b err=%h word=%h",
                         nm, act[35:34], act[33], act[32], act[31:16], act[15:0],
                         e[35:34], e[33], e[32], e[31:16], e[15:0]);
            end
        end
    endtask

    task automatic apply(input logic r, input logic v, input logic [7:0] d, input logic c,
                         input logic [EXP_W-1:0] e, input string nm);
        @(negedge clk);
        rst = r;
        m_bus.in_valid = v;
        m_bus.in_data = d;
        m_bus.clear_cnt = c;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_pop({2'(m_bus.state), m_bus.locked, m_bus.err_pulse, m_bus.err_count, m_bus.word_count}, nm);
    endtask

    task automatic apply_s(input logic r, input logic v, input logic [7:0] d,
                           input logic [EXP_W-1:0] e, input string nm);
        @(negedge clk);
        rst_s = r;
        s_bus.in_valid = v;
        s_bus.in_data = d;
        s_bus.clear_cnt = 1'b0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_pop({2'(s_bus.state), s_bus.locked, s_bus.err_pulse, s_bus.err_count, s_bus.word_count}, nm);
    endtask

    initial begin
        rst = 1'b1;
        rst_s = 1'b1;
        m_bus.in_valid = 1'b0; m_bus.in_data = 8'h00; m_bus.clear_cnt = 1'b0;
        s_bus.in_valid = 1'b0; s_bus.in_data = 8'h00; s_bus.clear_cnt = 1'b0;

        // Lock, single error, idle gap, clear, loss of lock, hunt on zeros, relock
        tbl[0]  = mk(1, 8'h01, 0, S, 0, 0, 16'd0, 16'd0);
        tbl[1]  = mk(1, 8'h02, 0, S, 0, 0, 16'd0, 16'd0);
        tbl[2]  = mk(1, 8'h04, 0, S, 0, 0, 16'd0, 16'd0);
        tbl[3]  = mk(1, 8'h08, 0, S, 0, 0, 16'd0, 16'd0);
        tbl[4]  = mk(1, 8'h11, 0, L, 1, 0, 16'd0, 16'd0);
        tbl[5]  = mk(1, 8'h23, 0, L, 1, 0, 16'd0, 16'd1);
        tbl[6]  = mk(1, 8'h00, 0, L, 1, 1, 16'd1, 16'd2);
        tbl[7]  = mk(1, 8'h8E, 0, L, 1, 0, 16'd1, 16'd3);
        for (int i = 8; i < 13; i++) tbl[i] = mk(0, 8'h00, 0, L, 1, 0, 16'd1, 16'd3);
        tbl[13] = mk(1, 8'h1C, 0, L, 1, 0, 16'd1, 16'd4);
        tbl[14] = mk(1, 8'h38, 0, L, 1, 0, 16'd1, 16'd5);
        tbl[15] = mk(1, 8'hFF, 1, L, 1, 1, 16'd0, 16'd0);
        tbl[16] = mk(1, 8'hE2, 0, L, 1, 0, 16'd0, 16'd1);
        tbl[17] = mk(1, 8'h00, 0, L, 1, 1, 16'd1, 16'd2);
        tbl[18] = mk(1, 8'h00, 0, L, 1, 1, 16'd2, 16'd3);
        tbl[19] = mk(1, 8'h00, 0, H, 0, 1, 16'd3, 16'd4);
        for (int i = 20; i < 23; i++) tbl[i] = mk(1, 8'h00, 0, H, 0, 0, 16'd3, 16'd4);
        tbl[23] = mk(1, 8'h01, 0, S, 0, 0, 16'd3, 16'd4);
        tbl[24] = mk(1, 8'h02, 0, S, 0, 0, 16'd3, 16'd4);
        tbl[25] = mk(1, 8'h04, 0, S, 0, 0, 16'd3, 16'd4);
        tbl[26] = mk(1, 8'h08, 0, S, 0, 0, 16'd3, 16'd4);
        tbl[27] = mk(1, 8'h11, 0, L, 1, 0, 16'd3, 16'd4);
        tbl[28] = mk(1, 8'h23, 0, L, 1, 0, 16'd3, 16'd5);
        tbl[29] = mk(0, 8'h00, 1, L, 1, 0, 16'd0, 16'd0);

        apply(1, 1, 8'h01, 1, pk(H, 0, 0, 16'd0, 16'd0), "reset_0");
        apply(1, 0, 8'h00, 0, pk(H, 0, 0, 16'd0, 16'd0), "reset_1");

        for (int i = 0; i < 30; i++) begin
            apply(0, tbl[i].v, tbl[i].d, tbl[i].c,
                  pk(tbl[i].st, tbl[i].lk, tbl[i].ep, tbl[i].ec, tbl[i].wc),
                  $sformatf("vec_%0d", i));
        end

        // Build up counts again, then reset mid-stream with valid and clear asserted
        apply(0, 1, 8'h00, 0, pk(L, 1, 1, 16'd1, 16'd1), "pre_rst_err");
        apply(1, 1, 8'h8E, 1, pk(H, 0, 0, 16'd0, 16'd0), "mid_rst");

        // SYNC mismatch reseeds; exactly LOCK_MATCHES matches after the new seed lock
        apply(0, 1, 8'h01, 0, pk(S, 0, 0, 16'd0, 16'd0), "rs_seed");
        apply(0, 1, 8'h02, 0, pk(S, 0, 0, 16'd0, 16'd0), "rs_m1");
        apply(0, 1, 8'h40, 0, pk(S, 0, 0, 16'd0, 16'd0), "rs_reseed");
        apply(0, 1, 8'h80, 0, pk(S, 0, 0, 16'd0, 16'd0), "rs_n1");
        apply(0, 1, 8'h01, 0, pk(S, 0, 0, 16'd0, 16'd0), "rs_n2");
        apply(0, 1, 8'h02, 0, pk(S, 0, 0, 16'd0, 16'd0), "rs_n3_not_locked");
        apply(0, 1, 8'h04, 0, pk(L, 1, 0, 16'd0, 16'd0), "rs_n4_locked");

        // A zero word in SYNC returns to HUNT; a zero word in HUNT stays there
        apply(1, 0, 8'h00, 0, pk(H, 0, 0, 16'd0, 16'd0), "rst_2");
        apply(0, 1, 8'h01, 0, pk(S, 0, 0, 16'd0, 16'd0), "sz_seed");
        apply(0, 1, 8'h00, 0, pk(H, 0, 0, 16'd0, 16'd0), "sz_zero_hunt");
        apply(0, 1, 8'h00, 0, pk(H, 0, 0, 16'd0, 16'd0), "hunt_zero");

        // Saturation on the long-loss instance
        apply_s(1, 0, 8'h00, pk(H, 0, 0, 16'd0, 16'd0), "sat_reset");
        apply_s(0, 1, 8'h01, pk(S, 0, 0, 16'd0, 16'd0), "sat_seed");
        apply_s(0, 1, 8'h02, pk(S, 0, 0, 16'd0, 16'd0), "sat_m1");
        apply_s(0, 1, 8'h04, pk(S, 0, 0, 16'd0, 16'd0), "sat_m2");
        apply_s(0, 1, 8'h08, pk(S, 0, 0, 16'd0, 16'd0), "sat_m3");
        apply_s(0, 1, 8'h11, pk(L, 1, 0, 16'd0, 16'd0), "sat_lock");
        for (int i = 0; i < 65533; i++) begin
            @(negedge clk);
            s_bus.in_valid = 1'b1;
            s_bus.in_data = 8'h00;
        end
        apply_s(0, 1, 8'h00, pk(L, 1, 1, 16'hFFFE, 16'hFFFE), "sat_fffe");
        apply_s(0, 1, 8'h00, pk(L, 1, 1, 16'hFFFF, 16'hFFFF), "sat_ffff");
        apply_s(0, 1, 8'h00, pk(L, 1, 1, 16'hFFFF, 16'hFFFF), "sat_hold");
        apply_s(0, 1, 8'h00, pk(L, 1, 1, 16'hFFFF, 16'hFFFF), "sat_hold2");
        apply_s(1, 1, 8'h00, pk(H, 0, 0, 16'd0, 16'd0), "sat_mid_rst");

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
